uart_tx_arbiter: RTL and testbench

Shares a single UART transmitter among `NumReq` byte-stream requesters. Requesters are served round-robin. A requester keeps the grant for a whole message: the grant is released when a byte marked Last is accepted, or after `BurstLimit` bytes, whichever comes first. The block sits between the on-chip producers (console, debug dump, status reporter) and the transmitter's `DataIn`/`DataInValid`/`DataInReady` port.

---
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter byte port among several requesters.
// The owner keeps the grant until a Last byte is accepted or the burst limit is reached.
module uart_tx_arbiter #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned BurstLimit = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [8*NumReq-1:0] req_data_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [NumReq-1:0]   req_last_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic [NumReq-1:0]   grant_o,
    output logic                busy_o
);

    localparam int unsigned PtrW  = $clog2(NumReq);
    localparam logic [8:0]  Limit = 9'(BurstLimit);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e              state_q, state_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [7:0]          count_q, count_d;
    logic [PtrW-1:0]     owner_idx, sel_idx;
    logic                found, xfer, limit_hit;

    always_comb begin
        owner_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (grant_q[i]) owner_idx = PtrW'(i);
        end
    end

    // First pass covers ptr..NumReq-1, second pass the wrapped part 0..ptr-1.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && req_valid_i[i] && (i >= 32'(ptr_q))) begin
                found   = 1'b1;
                sel_idx = PtrW'(i);
            end
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && req_valid_i[i]) begin
                found   = 1'b1;
                sel_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        req_ready_o = '0;
        tx_data_o   = 8'h00;
        tx_valid_o  = 1'b0;
        xfer        = 1'b0;
        limit_hit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StLocked;
                    grant_d = NumReq'(1) << sel_idx;
                    count_d = '0;
                end
            end
            StLocked: begin
                tx_data_o   = req_data_i[{owner_idx, 3'b000} +: 8];
                tx_valid_o  = req_valid_i[owner_idx];
                req_ready_o = grant_q & {NumReq{tx_ready_i}};
                xfer        = tx_valid_o & tx_ready_i;
                limit_hit   = (Limit != 9'd0) && (({1'b0, count_q} + 9'd1) == Limit);
                if (xfer) begin
                    if (req_last_i[owner_idx] || limit_hit) begin
                        state_d = StIdle;
                        grant_d = '0;
                        count_d = '0;
                        ptr_d   = (owner_idx == PtrW'(NumReq - 1)) ? '0 : owner_idx + 1'b1;
                    end else if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == StLocked);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a transaction-level arbitration model
// checked every cycle, plus directed scenarios for ordering, locking, limits, stalls and reset.
module tb_uart_tx_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned LIMIT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_ready, busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NumReq(N), .BurstLimit(LIMIT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_data_i (req_data),
        .req_valid_i(req_valid),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [8:0] msgq [N][$];   // {last, data}
    bit         stall [N];
    int         ready_pct;

    // Reference: owner (-1 when idle), round-robin start, bytes sent in current grant.
    int m_owner, m_ptr, m_count;

    int         glog [$];
    logic [7:0] txlog [$];
    logic [N-1:0] prev_grant;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (msgq[i].size() > 0 && !stall[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = msgq[i][0][7:0];
                req_last[i]         = msgq[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        tx_ready = ($urandom_range(99) < 32'(ready_pct));
    endtask

    task automatic cycle();
        logic [N-1:0] e_grant, e_rdy;
        logic         e_busy, e_txv;
        logic [7:0]   e_txd;
        int           acc;
        drive();
        #1;
        if (m_owner < 0) begin
            e_grant = '0; e_rdy = '0; e_busy = 1'b0; e_txv = 1'b0; e_txd = 8'h00;
        end else begin
            e_grant = N'(1) << m_owner;
            e_busy  = 1'b1;
            e_txv   = req_valid[m_owner];
            e_txd   = req_data[8*m_owner +: 8];
            e_rdy   = tx_ready ? e_grant : '0;
        end
        check("grant", 32'(grant), 32'(e_grant));
        check("busy", 32'(busy), 32'(e_busy));
        check("tx_valid", 32'(tx_valid), 32'(e_txv));
        check("tx_data", 32'(tx_data), 32'(e_txd));
        check("req_ready", 32'(req_ready), 32'(e_rdy));
        if (grant != '0 && prev_grant == '0) glog.push_back(oh_idx(grant));
        prev_grant = grant;
        if (tx_valid && tx_ready) txlog.push_back(tx_data);

        acc = -1;
        if (m_owner >= 0 && req_valid[m_owner] && tx_ready) acc = m_owner;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_count = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_count = 0;
                end
            end
        end else if (acc >= 0) begin
            m_count++;
            if (req_last[acc] || m_count == LIMIT) begin
                m_ptr   = (acc + 1) % N;
                m_owner = -1;
                m_count = 0;
            end
        end
        @(posedge clk);
        if (acc >= 0) void'(msgq[acc].pop_front());
        @(negedge clk);
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            msgq[i].delete();
            stall[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        flush();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        glog.delete();
        txlog.delete();
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (msgq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (any_pending() && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        cycle();
        cycle();
    endtask

    task automatic check_log(input string tag, input int exp []);
        check({tag, "_len"}, 32'(glog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < glog.size()) check(tag, 32'(glog[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        m_owner = -1; m_ptr = 0; m_count = 0; prev_grant = '0; ready_pct = 50;
        flush();
        @(negedge clk);
        do_reset();
        cycle();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single requester r1, three bytes.
        msgq[1].push_back(9'h041); msgq[1].push_back(9'h042); msgq[1].push_back(9'h143);
        cycle();
        check("single_grant", 32'(grant), 32'h2);
        drain(200);
        check("single_txlen", 32'(txlog.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < txlog.size()) check("single_txdata", 32'(txlog[i]), 32'h41 + 32'(i));
        check("single_idle", 32'(busy), 32'd0);
        glog.delete();
        msgq[0].push_back(9'h100); msgq[2].push_back(9'h100);
        drain(200);
        check_log("ptr_after_r1", '{2, 0});

        // Round-robin, one-byte messages, r0 twice.
        do_reset();
        ready_pct = 100;
        for (int i = 0; i < N; i++) msgq[i].push_back({1'b1, 8'(i)});
        msgq[0].push_back(9'h1AA);
        drain(200);
        check_log("rr", '{0, 1, 2, 3, 0});

        // Message lock; 4th byte carries Last and hits the limit together.
        do_reset();
        ready_pct = 50;
        for (int b = 0; b < 4; b++) msgq[0].push_back({1'(b == 3), 8'(8'h10 + b)});
        msgq[2].push_back(9'h1EE);
        drain(300);
        check_log("lock", '{0, 2});

        // Burst limit: r3 twelve bytes without Last, r1 joins after r3 is granted.
        do_reset();
        for (int b = 0; b < 12; b++) msgq[3].push_back({1'b0, 8'(b)});
        cycle();
        msgq[1].push_back(9'h051); msgq[1].push_back(9'h152);
        drain(400);
        check_log("burst", '{3, 1, 3, 3});

        // Owner stall.
        do_reset();
        ready_pct = 100;
        msgq[0].push_back(9'h001); msgq[0].push_back(9'h002); msgq[0].push_back(9'h103);
        cycle();
        cycle();
        stall[0] = 1'b1;
        msgq[1].push_back(9'h1BB);
        for (int c = 0; c < 20; c++) begin
            cycle();
            check("stall_grant", 32'(grant), 32'h1);
            check("stall_r1_ready", 32'(req_ready[1]), 32'd0);
        end
        stall[0] = 1'b0;
        drain(200);
        check_log("stall", '{0, 1});

        // Reset during r2's second byte.
        do_reset();
        msgq[2].push_back(9'h021); msgq[2].push_back(9'h022); msgq[2].push_back(9'h123);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_txvalid", 32'(tx_valid), 32'd0);
        flush();
        glog.delete();
        msgq[2].push_back(9'h1C2); msgq[3].push_back(9'h1C3);
        drain(200);
        check_log("rstmid", '{2, 3});

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) ready_pct = 30 + $urandom_range(70);
            for (int i = 0; i < N; i++) begin
                if (msgq[i].size() < 4 && $urandom_range(99) < 5) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++)
                        msgq[i].push_back({1'((b == len - 1) && ($urandom_range(9) != 0)),
                                           8'($urandom)});
                end
                stall[i] = ($urandom_range(99) < 10);
            end
            cycle();
        end
        for (int i = 0; i < N; i++) begin
            stall[i] = 1'b0;
            msgq[i].push_back({1'b1, 8'($urandom)});
        end
        ready_pct = 100;
        drain(2000);
        check("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
